// File: rtl/tone_seq_pkg.sv
// Shared types and default sizing for the tone sequencer.
package tone_seq_pkg;
    localparam int STEPS_DEF    = 16;
    localparam int DUR_W_DEF    = 10;
    localparam int TICK_DIV_DEF = 100000;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, END} state_t;

    typedef struct packed {
        logic [15:0]          divisor;
        logic [DUR_W_DEF-1:0] duration;
    } step_entry_t;
endpackage

// File: rtl/tone_sequencer_phase_stepper.sv
// Divisor counter and 8-bit phase accumulator; clear zeroes phase, disable zeroes only the counter.
module phase_stepper (
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] divisor,
    output logic [7:0]  phase
);
    logic [15:0] count;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
            phase <= '0;
        end else if (clear) begin
            count <= '0;
            phase <= '0;
        end else if (enable) begin
            if (count == divisor) begin
                count <= '0;
                phase <= phase + 8'd1;
            end else begin
                count <= count + 16'd1;
            end
        end else begin
            count <= '0;
        end
    end
endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: plays a divisor/duration step table into the phase path and gates AUD_SD.
// Define TONE_SEQ_LOOP_EN to repeat the table until stop instead of playing it once.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int STEPS    = STEPS_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    localparam int IDX_W   = $clog2(STEPS)
) (
    input  logic             CLK_100M,
    input  logic             CPU_RESETN,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [15:0]      wr_divisor,
    input  logic [DUR_W-1:0] wr_duration,
    input  logic             start,
    input  logic             stop,
    output logic [7:0]       phase,
    output logic             AUD_SD,
    output logic             busy,
    output logic [IDX_W-1:0] step_idx,
    output logic             done
);
    // state | meaning
    // IDLE  | silent, waiting for start
    // LOAD  | latch entry step_idx, clear counters
    // PLAY  | tone running for duration ticks
    // END   | one-cycle done pulse
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STEPS - 1);

    state_t state, state_nxt;
    logic [15:0]       div_mem [STEPS];
    logic [DUR_W-1:0]  dur_mem [STEPS];
    logic [15:0]       cur_div;
    logic [DUR_W-1:0]  remaining;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick, step_end, phase_clear;
`ifdef TONE_SEQ_LOOP_EN
    logic              empty_table;
`endif

    always_ff @(posedge CLK_100M) begin
        if (wr_en) begin
            div_mem[wr_addr] <= wr_divisor;
            dur_mem[wr_addr] <= wr_duration;
        end
    end

    assign tick     = (tick_cnt == '0);
    assign step_end = tick && (remaining == DUR_W'(1));

    always_comb begin
        state_nxt   = state;
        phase_clear = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt   = LOAD;
                phase_clear = 1'b1;
            end
            LOAD: state_nxt = (dur_mem[step_idx] == '0) ? END : PLAY;
            PLAY: if (step_end) state_nxt = (step_idx == IDX_LAST) ? END : LOAD;
`ifdef TONE_SEQ_LOOP_EN
            END:  state_nxt = empty_table ? IDLE : LOAD;
`else
            END:  state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt   = IDLE;
            phase_clear = 1'b0;
        end
    end

    always_ff @(posedge CLK_100M or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state     <= IDLE;
            step_idx  <= '0;
            cur_div   <= '0;
            remaining <= '0;
            tick_cnt  <= '0;
`ifdef TONE_SEQ_LOOP_EN
            empty_table <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (!stop) begin
                case (state)
                    IDLE: if (start) step_idx <= '0;
                    LOAD: begin
                        cur_div   <= div_mem[step_idx];
                        remaining <= dur_mem[step_idx];
                        tick_cnt  <= TICK_LAST;
`ifdef TONE_SEQ_LOOP_EN
                        // only an empty step 0 stops the loop; avoids spinning on LOAD/END
                        empty_table <= (step_idx == '0) && (dur_mem[step_idx] == '0);
`endif
                    end
                    PLAY: begin
                        if (tick) begin
                            tick_cnt  <= TICK_LAST;
                            remaining <= remaining - 1'b1;
                            if (step_end && step_idx != IDX_LAST) step_idx <= step_idx + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt - 1'b1;
                        end
                    end
`ifdef TONE_SEQ_LOOP_EN
                    END: if (!empty_table) step_idx <= '0;
`endif
                    default: ;
                endcase
            end
        end
    end

    phase_stepper u_phase_stepper (
        .clk_sys (CLK_100M),
        .rst_b   (CPU_RESETN),
        .enable  (state == PLAY),
        .clear   (phase_clear),
        .divisor (cur_div),
        .phase   (phase)
    );

    assign AUD_SD = (state == PLAY);
    assign busy   = (state == LOAD) || (state == PLAY);
    assign done   = (state == END);
endmodule
